pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised pipeline stage register, successor to the fixed-field decode/execute latch.
//  Carries an opaque payload (operands, immediate, pc) and a control bundle between two pipeline stages.
//  Adds a valid/ready handshake, a 2-entry skid buffer so in_ready is registered, plus stall and flush.
//  Instantiated between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-stage widths.
// PARAMETERS
//  DATA_W  96  payload width; held (not cleared) on flush
//  CTRL_W  32  control bundle width; cleared to 0 on flush/bubble (all-zero = nop)
//  CNT_W   16  perf counter width (used only with STAGE_PERF_CNT_EN)
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       asynchronous, active-low reset
//  in_valid     in   1       upstream entry valid
//  in_ready     out  1       stage can accept; registered, = ~skid_valid
//  in_data      in   DATA_W  upstream payload
//  in_ctrl      in   CTRL_W  upstream control bundle
//  out_valid    out  1       main entry valid
//  out_ready    in   1       downstream accepts
//  out_data     out  DATA_W  main entry payload
//  out_ctrl     out  CTRL_W  main entry control; 0 whenever out_valid=0
//  stall        in   1       hold stage contents; blocks output transfer
//  flush        in   1       kill all entries
//  occupancy    out  2       entries held: 0, 1 or 2
// BEHAVIOUR
//  Reset (async, reset_n=0): main/skid valid=0, data=0, ctrl=0; in_ready=1, out_valid=0, occupancy=0.
//  acc = in_valid & in_ready & ~flush;  take = out_valid & out_ready & ~stall & ~flush.
//  States: EMPTY (occ 0), ONE (main valid), TWO (main + skid valid).
//   EMPTY: acc -> ONE, main<=in.
//   ONE: acc&take -> ONE, main<=in; acc&~take -> TWO, skid<=in; ~acc&take -> EMPTY; else hold.
//   TWO: take -> ONE, main<=skid; else hold. in_ready=0, so no acc in TWO.
//  flush has top priority in every state: next state EMPTY, valids=0, ctrl regs=0, data regs hold; no acc, no take that cycle.
//  stall=1 (no flush): main and skid hold. acc still allowed, so ONE -> TWO is possible.
//  Latency 1 cycle, EMPTY in -> out_valid. Throughput 1 entry/cycle in ONE with out_ready=1.
//  Strict FIFO order: the skid entry is always older than any new input.
//  Downstream must not count a cycle with flush=1 or stall=1 as a transfer.
//  in_ready and out_valid are driven only from flops; no combinational in->out path.
// CONFIGURATION
//  STAGE_PERF_CNT_EN defined:
//   - adds ports stall_cnt and flush_cnt, each out CNT_W, reset to 0.
//   - stall_cnt += 1 each cycle with stall & out_valid.
//   - flush_cnt += occupancy on each flush cycle.
//   - both counters saturate at all-ones.
//  STAGE_PERF_CNT_EN undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  T1 reset: reset_n=0 mid-stream, occ=2 -> same cycle out_valid=0, out_ctrl=0, in_ready=1, occupancy=0.
//  T2 streaming: in_data=1..8 every cycle, out_ready=1 -> out_data 1..8 on consecutive cycles, 1-cycle latency, occupancy stays 1.
//  T3 backpressure: out_ready=0 after entry A, then B presented -> occ=2, in_ready=0; out_ready=1 -> A then B out, in_ready=1 one cycle later.
//  T4 flush: occ=2, ctrl=32'hFF, data=96'h5 -> next cycle out_valid=0, out_ctrl=0, out_data=96'h5, in_ready=1; a same-cycle in_valid is dropped.
//  T5 stall vs ready: stall=1, out_ready=1 for 3 cycles, in_valid=1 -> no transfer, occ 1->2, then in_ready=0; stall=0 -> drains in order.
//  T6 perf (STAGE_PERF_CNT_EN): 5 stall cycles with out_valid=1, then flush at occ=2 -> stall_cnt=5, flush_cnt=2.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline stage register with a valid/ready handshake.
// It has a 2-entry skid buffer so that in_ready comes straight from a flop.
// It carries an opaque payload and a control bundle between two pipeline
// stages, and supports stall and flush.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready registered)
//   in_data, in_ctrl      upstream payload / control bundle
//   out_valid/out_ready   downstream handshake (out_valid registered)
//   out_data, out_ctrl    head entry; out_ctrl is 0 whenever out_valid is 0
//   stall                 hold contents and block output transfer
//   flush                 kill all entries (ctrl cleared, data held)
//   occupancy             number of entries held (0..2)
//   stall_cnt, flush_cnt  perf counters, present only with STAGE_PERF_CNT_EN
//
// Optional feature macro: STAGE_PERF_CNT_EN (adds saturating perf counters).
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 32
`ifdef STAGE_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef STAGE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              acc;
  logic              take;

  // Both qualifiers use only registered handshake outputs, so there is no
  // combinational path from the inputs to in_ready or out_valid.
  always_comb begin
    acc  = in_valid & in_ready & ~flush;
    take = out_valid & out_ready & ~stall & ~flush;
  end

  // out_data/out_ctrl are the main register itself. A bubble clears the
  // control bundle (all-zero = nop) and leaves the payload untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_ctrl  <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else if (flush) begin
      state     <= EMPTY;
      out_ctrl  <= '0;
      skid_ctrl <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state     <= ONE;
            out_data  <= in_data;
            out_ctrl  <= in_ctrl;
            out_valid <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        ONE: begin
          if (acc && take) begin
            out_data <= in_data;
            out_ctrl <= in_ctrl;
          end else if (acc) begin
            // The head is still waiting, so the new entry parks behind it.
            state     <= TWO;
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            in_ready  <= 1'b0;
            occupancy <= 2'd2;
          end else if (take) begin
            state     <= EMPTY;
            out_ctrl  <= '0;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
          end
        end
        TWO: begin
          // in_ready is 0 here, so nothing can be accepted in this state.
          if (take) begin
            state     <= ONE;
            out_data  <= skid_data;
            out_ctrl  <= skid_ctrl;
            skid_ctrl <= '0;
            in_ready  <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_ctrl  <= '0;
          skid_ctrl <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          occupancy <= 2'd0;
        end
      endcase
    end
  end

`ifdef STAGE_PERF_CNT_EN
  logic [CNT_W:0] stall_sum;
  logic [CNT_W:0] flush_sum;

  always_comb begin
    stall_sum = {1'b0, stall_cnt} + (CNT_W+1)'(1);
    flush_sum = {1'b0, flush_cnt} + (CNT_W+1)'(occupancy);
  end

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && out_valid)
        stall_cnt <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
      if (flush)
        flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf. It runs directed table vectors,
// hand-written corner sequences and random traffic. All of them are compared
// against a queue-based reference model.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 96;
  localparam int unsigned CW = 32;
  localparam int CNT_MAX = 65535;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    occupancy;
`ifdef STAGE_PERF_CNT_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   flush_cnt;
`endif

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall(stall), .flush(flush), .occupancy(occupancy)
`ifdef STAGE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } entry_t;

  // Reference model: an in-order queue of at most two entries.
  entry_t        mq[$];
  logic [DW-1:0] m_held;
  int            m_stall;
  int            m_flush;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_held = '0;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_edge(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                            input logic ordy, input logic st, input logic fl);
    int sz;
    entry_t e;
    sz = mq.size();
    if (st && sz > 0) m_stall = (m_stall + 1 > CNT_MAX) ? CNT_MAX : m_stall + 1;
    if (fl) begin
      m_flush = (m_flush + sz > CNT_MAX) ? CNT_MAX : m_flush + sz;
      mq.delete();
    end else begin
      if (sz > 0 && ordy && !st) void'(mq.pop_front());
      if (iv && sz < 2) begin
        e.data = d;
        e.ctrl = c;
        mq.push_back(e);
      end
    end
    if (mq.size() > 0) m_held = mq[0].data;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out_valid"}, 128'(out_valid), 128'(mq.size() > 0));
    check({tag, ".in_ready"},  128'(in_ready),  128'(mq.size() < 2));
    check({tag, ".occupancy"}, 128'(occupancy), 128'(mq.size()));
    check({tag, ".out_data"},  128'(out_data),  128'(m_held));
    check({tag, ".out_ctrl"},  128'(out_ctrl),  128'(mq.size() > 0 ? mq[0].ctrl : '0));
`ifdef STAGE_PERF_CNT_EN
    check({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(m_stall));
    check({tag, ".flush_cnt"}, 128'(flush_cnt), 128'(m_flush));
`endif
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model #1 later.
  task automatic step(input string tag, input logic iv, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input logic ordy, input logic st, input logic fl);
    in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy; stall = st; flush = fl;
    @(posedge clk);
    #1;
    model_edge(iv, d, c, ordy, st, fl);
    check_model(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    #1;
    model_reset();
    check_model("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy, st, fl;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [CW-1:0] e_oc;
    logic          e_ir;
    logic [1:0]    e_occ;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // backpressure: A held, B skidded, C refused, then A then B drain
    vecs[0]  = '{1'b1, 96'h11, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 96'h11, 32'h1, 1'b1, 2'd1};
    vecs[1]  = '{1'b1, 96'h22, 32'h2, 1'b0, 1'b0, 1'b0, 1'b1, 96'h11, 32'h1, 1'b0, 2'd2};
    vecs[2]  = '{1'b1, 96'h33, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, 96'h11, 32'h1, 1'b0, 2'd2};
    vecs[3]  = '{1'b0, 96'h0,  32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 96'h22, 32'h2, 1'b1, 2'd1};
    vecs[4]  = '{1'b0, 96'h0,  32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 96'h22, 32'h0, 1'b1, 2'd0};
    // flush at occupancy 2: ctrl cleared, data held, same-cycle input dropped
    vecs[5]  = '{1'b1, 96'h5,  32'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 96'h5, 32'hFF, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 96'h6,  32'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 96'h5, 32'hFF, 1'b0, 2'd2};
    vecs[7]  = '{1'b1, 96'h7,  32'h7,  1'b1, 1'b0, 1'b1, 1'b0, 96'h5, 32'h0,  1'b1, 2'd0};
    vecs[8]  = '{1'b0, 96'h0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 96'h5, 32'h0,  1'b1, 2'd0};
    // stall with out_ready=1: entries accumulate, then drain in order
    vecs[9]  = '{1'b1, 96'h31, 32'h31, 1'b1, 1'b1, 1'b0, 1'b1, 96'h31, 32'h31, 1'b1, 2'd1};
    vecs[10] = '{1'b1, 96'h32, 32'h32, 1'b1, 1'b1, 1'b0, 1'b1, 96'h31, 32'h31, 1'b0, 2'd2};
    vecs[11] = '{1'b1, 96'h33, 32'h33, 1'b1, 1'b1, 1'b0, 1'b1, 96'h31, 32'h31, 1'b0, 2'd2};
    vecs[12] = '{1'b0, 96'h0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 96'h32, 32'h32, 1'b1, 2'd1};
    vecs[13] = '{1'b0, 96'h0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 96'h32, 32'h0,  1'b1, 2'd0};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      step("table", vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, vecs[i].st, vecs[i].fl);
      check($sformatf("vec%0d.out_valid", i), 128'(out_valid), 128'(vecs[i].e_ov));
      check($sformatf("vec%0d.out_data", i),  128'(out_data),  128'(vecs[i].e_od));
      check($sformatf("vec%0d.out_ctrl", i),  128'(out_ctrl),  128'(vecs[i].e_oc));
      check($sformatf("vec%0d.in_ready", i),  128'(in_ready),  128'(vecs[i].e_ir));
      check($sformatf("vec%0d.occupancy", i), 128'(occupancy), 128'(vecs[i].e_occ));
    end

    // streaming 1..8 with out_ready=1: one-cycle latency, occupancy stays 1
    for (int k = 1; k <= 8; k++) begin
      step("stream", 1'b1, DW'(k), CW'(k + 100), 1'b1, 1'b0, 1'b0);
      check($sformatf("stream%0d.out_data", k), 128'(out_data), 128'(k));
      check($sformatf("stream%0d.occupancy", k), 128'(occupancy), 128'(1));
    end
    step("stream_end", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // asynchronous reset mid-stream with two entries held
    step("pre_rst", 1'b1, 96'hA1, 32'hA1, 1'b0, 1'b0, 1'b0);
    step("pre_rst", 1'b1, 96'hA2, 32'hA2, 1'b0, 1'b0, 1'b0);
    check("pre_rst.occupancy", 128'(occupancy), 128'(2));
    reset_n = 1'b0;
    #1;
    check("async_rst.out_valid", 128'(out_valid), 128'(0));
    check("async_rst.out_ctrl",  128'(out_ctrl),  128'(0));
    check("async_rst.in_ready",  128'(in_ready),  128'(1));
    check("async_rst.occupancy", 128'(occupancy), 128'(0));
    do_reset();

`ifdef STAGE_PERF_CNT_EN
    // perf counters: 5 stall cycles with out_valid=1, then flush at occupancy 2
    step("perf", 1'b1, 96'hB1, 32'hB1, 1'b0, 1'b0, 1'b0);
    step("perf", 1'b1, 96'hB2, 32'hB2, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step("perf", 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    step("perf", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("perf.stall_cnt", 128'(stall_cnt), 128'(5));
    check("perf.flush_cnt", 128'(flush_cnt), 128'(2));
    do_reset();
`endif

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom}, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 24) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
